// File: rtl/label_table_ctrl_pkg.sv
// Shared definitions for the label table controller: widths, type codes, FSM states.
package label_table_ctrl_pkg;

  localparam int LBID_W_DEF = 12;
  localparam int TYP_W      = 8;
  localparam int ADDR_W     = 16;

  localparam logic [TYP_W-1:0] TYP_UNDEF = 8'h00;
  localparam logic [TYP_W-1:0] TYP_VPTR  = 8'h01;
  localparam logic [TYP_W-1:0] TYP_UINT1 = 8'h0D;
  localparam logic [TYP_W-1:0] TYP_CODE  = 8'h86;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/label_table_ctrl_arb.sv
// Two-way round-robin grant for the shared table read port.
// rr holds the id granted last; on contention the other requester wins.
module lbl_rr_arb2
  import label_table_ctrl_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       rr,
  input  logic       inhibit,
  output logic [1:0] grant
);

  // One-hot grant, suppressed entirely while inhibited
  always_comb begin
    grant = 2'b00;
    if (!inhibit) begin
      if (valid == 2'b11) grant = rr ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end

endmodule

// File: rtl/label_table_ctrl.sv
// Label table sequencer: power-up/soft clear, bump-pointer allocation for
// label definitions, and round-robin sharing of the table read port.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | writing typ 0x00 to every LBID, one per cycle; no requests taken
// ST_IDLE  | accepting define requests and granting table reads
module label_table_ctrl
  import label_table_ctrl_pkg::*;
#(
  parameter int LBID_W     = LBID_W_DEF,
  parameter int NUM_LABELS = 4096,
  parameter int MEM_WORDS  = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  input  logic              def_valid,
  output logic              def_ready,
  input  logic [LBID_W-1:0] def_lbid,
  input  logic [7:0]        def_typ,
  input  logic [15:0]       def_count,
  input  logic [15:0]       def_cbase,
  output logic              def_done,
  output logic              def_err,
  input  logic [1:0]        rd_valid,
  input  logic [LBID_W-1:0] rd_lbid0,
  input  logic [LBID_W-1:0] rd_lbid1,
  output logic [1:0]        rd_ready,
  output logic [1:0]        rsp_valid,
  output logic [7:0]        rsp_typ,
  output logic [15:0]       rsp_base,
  output logic [15:0]       rsp_count,
  output logic [LBID_W-1:0] tbl_lbid,
  input  logic [7:0]        tbl_typ,
  input  logic [15:0]       tbl_base,
  input  logic [15:0]       tbl_count,
  output logic              tbl_we,
  output logic [LBID_W-1:0] tbl_lbidw,
  output logic [7:0]        tbl_typw,
  output logic [15:0]       tbl_basew,
  output logic [15:0]       tbl_countw
);

  state_t            state;
  logic [LBID_W-1:0] clr_idx;
  logic [15:0]       alloc_ptr;
  logic              rr;
  logic [16:0]       need;
  logic              need_ovf;
  logic              clr_last;
  logic              rd_inhibit;

  assign busy      = (state == ST_CLEAR);
  assign def_ready = (state == ST_IDLE) && !clr_req;
  assign clr_last  = (clr_idx == LBID_W'(NUM_LABELS - 1));

  // Allocation size is 17 bits so an exact fit at the top of memory is legal
  assign need     = {1'b0, alloc_ptr} + {1'b0, def_count};
  assign need_ovf = ({15'd0, need} > MEM_WORDS);

  // Reads never share an edge with a table write, and stop as soon as a clear starts
  assign rd_inhibit = (state != ST_IDLE) || clr_req || tbl_we;

  lbl_rr_arb2 u_arb (
    .valid   (rd_valid),
    .rr      (rr),
    .inhibit (rd_inhibit),
    .grant   (rd_ready)
  );

  assign tbl_lbid = rd_ready[1] ? rd_lbid1 : rd_lbid0;

  // Sequencer FSM: clear walk, define handling, registered table write bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      clr_idx    <= '0;
      alloc_ptr  <= '0;
      tbl_we     <= 1'b0;
      tbl_lbidw  <= '0;
      tbl_typw   <= '0;
      tbl_basew  <= '0;
      tbl_countw <= '0;
      def_done   <= 1'b0;
      def_err    <= 1'b0;
    end else begin
      tbl_we   <= 1'b0;
      def_done <= 1'b0;
      def_err  <= 1'b0;
      case (state)
        ST_CLEAR: begin
          tbl_we     <= 1'b1;
          tbl_lbidw  <= clr_idx;
          tbl_typw   <= TYP_UNDEF;
          tbl_basew  <= '0;
          tbl_countw <= '0;
          clr_idx    <= clr_idx + LBID_W'(1);
          if (clr_last) begin
            state     <= ST_IDLE;
            alloc_ptr <= '0;
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
          end else if (def_valid) begin
            if (def_typ == TYP_UNDEF) begin
              def_err <= 1'b1;
            end else if (def_typ == TYP_CODE) begin
              tbl_we     <= 1'b1;
              def_done   <= 1'b1;
              tbl_lbidw  <= def_lbid;
              tbl_typw   <= def_typ;
              tbl_basew  <= def_cbase;
              tbl_countw <= def_count;
            end else if (need_ovf) begin
              def_err <= 1'b1;
            end else begin
              tbl_we     <= 1'b1;
              def_done   <= 1'b1;
              tbl_lbidw  <= def_lbid;
              tbl_typw   <= def_typ;
              tbl_basew  <= alloc_ptr;
              tbl_countw <= def_count;
              alloc_ptr  <= need[15:0];
            end
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Read response capture and round-robin pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr        <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_typ   <= '0;
      rsp_base  <= '0;
      rsp_count <= '0;
    end else begin
      rsp_valid <= rd_ready;
      if (rd_ready != 2'b00) begin
        rr        <= rd_ready[1];
        rsp_typ   <= tbl_typ;
        rsp_base  <= tbl_base;
        rsp_count <= tbl_count;
      end
    end
  end

endmodule

// File: tb/tb_label_table_ctrl.sv
// Directed bench for label_table_ctrl with a small behavioural label table.
module tb_label_table_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_req = 1'b0;
  logic        busy;
  logic        def_valid = 1'b0;
  logic        def_ready;
  logic [11:0] def_lbid = '0;
  logic [7:0]  def_typ = '0;
  logic [15:0] def_count = '0;
  logic [15:0] def_cbase = '0;
  logic        def_done, def_err;
  logic [1:0]  rd_valid = 2'b00;
  logic [11:0] rd_lbid0 = '0;
  logic [11:0] rd_lbid1 = '0;
  logic [1:0]  rd_ready, rsp_valid;
  logic [7:0]  rsp_typ;
  logic [15:0] rsp_base, rsp_count;
  logic [11:0] tbl_lbid;
  logic [7:0]  tbl_typ;
  logic [15:0] tbl_base, tbl_count;
  logic        tbl_we;
  logic [11:0] tbl_lbidw;
  logic [7:0]  tbl_typw;
  logic [15:0] tbl_basew, tbl_countw;

  int errors = 0;
  int checks = 0;

  logic [39:0] mem [4096];

  always #5 clk = ~clk;

  label_table_ctrl #(.LBID_W(12), .NUM_LABELS(16), .MEM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy),
    .def_valid(def_valid), .def_ready(def_ready), .def_lbid(def_lbid),
    .def_typ(def_typ), .def_count(def_count), .def_cbase(def_cbase),
    .def_done(def_done), .def_err(def_err),
    .rd_valid(rd_valid), .rd_lbid0(rd_lbid0), .rd_lbid1(rd_lbid1),
    .rd_ready(rd_ready), .rsp_valid(rsp_valid), .rsp_typ(rsp_typ),
    .rsp_base(rsp_base), .rsp_count(rsp_count),
    .tbl_lbid(tbl_lbid), .tbl_typ(tbl_typ), .tbl_base(tbl_base), .tbl_count(tbl_count),
    .tbl_we(tbl_we), .tbl_lbidw(tbl_lbidw), .tbl_typw(tbl_typw),
    .tbl_basew(tbl_basew), .tbl_countw(tbl_countw)
  );

  // Table model: combinational read, write on edge; junk until cleared
  assign {tbl_typ, tbl_base, tbl_count} = mem[tbl_lbid];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 40'hFF_FFFF_FFFF;
    end else if (tbl_we) begin
      mem[tbl_lbidw] <= {tbl_typw, tbl_basew, tbl_countw};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_def(input logic [11:0] l, input logic [7:0] t,
                         input logic [15:0] c, input logic [15:0] cb);
    def_valid = 1'b1;
    def_lbid  = l;
    def_typ   = t;
    def_count = c;
    def_cbase = cb;
  endtask

  initial begin
    // Reset values
    repeat (2) tick;
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_outs", 64'({tbl_we, def_ready, rd_ready, rsp_valid, def_done, def_err}), 64'd0);
    chk("rst_rsp", 64'({rsp_typ, rsp_base, rsp_count}), 64'd0);

    // 1: power-up clear walks 0..15
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("clr_busy", 64'({busy, def_ready}), 64'b10);
      tick;
      chk("clr_wr", 64'({tbl_we, tbl_lbidw, tbl_typw, tbl_basew, tbl_countw}),
          64'({1'b1, 12'(i), 8'h00, 16'h0, 16'h0}));
    end
    chk("clr_end", 64'({busy, def_ready}), 64'b01);
    rd_valid = 2'b01; rd_lbid0 = 12'd3;
    #1 chk("rd_inh_we", 64'(rd_ready), 64'd0);
    tick;
    chk("rd_inh_rsp", 64'(rsp_valid), 64'd0);
    #1 chk("rd_single0", 64'(rd_ready), 64'b01);
    tick;
    chk("rd_cleared", 64'({rsp_valid, rsp_typ, rsp_base, rsp_count}), 64'({2'b01, 40'h0}));
    rd_valid = 2'b00;

    // 2: two data definitions
    set_def(12'd3, 8'h02, 16'd10, 16'h0);
    #1 chk("def_ready", 64'(def_ready), 64'd1);
    tick;
    chk("def3", 64'({tbl_we, def_done, def_err, tbl_lbidw, tbl_typw, tbl_basew, tbl_countw}),
        64'({3'b110, 12'd3, 8'h02, 16'd0, 16'd10}));
    set_def(12'd4, 8'h06, 16'd20, 16'h0);
    tick;
    chk("def4", 64'({tbl_we, def_done, def_err, tbl_lbidw, tbl_typw, tbl_basew, tbl_countw}),
        64'({3'b110, 12'd4, 8'h06, 16'd10, 16'd20}));

    // 3: overflow then exact fit
    set_def(12'd5, 8'h03, 16'd35, 16'h0);
    tick;
    chk("def_ovf", 64'({tbl_we, def_done, def_err}), 64'b001);
    set_def(12'd5, 8'h03, 16'd34, 16'h0);
    tick;
    chk("def_fit", 64'({tbl_we, def_done, def_err, tbl_lbidw, tbl_typw, tbl_basew, tbl_countw}),
        64'({3'b110, 12'd5, 8'h03, 16'd30, 16'd34}));
    set_def(12'd6, 8'h01, 16'd1, 16'h0);
    tick;
    chk("def_full", 64'({tbl_we, def_done, def_err}), 64'b001);

    // 4: code label, undefined type, pointer untouched by code label
    set_def(12'd7, 8'h86, 16'd9, 16'h1234);
    tick;
    chk("def_code", 64'({tbl_we, def_done, def_err, tbl_lbidw, tbl_typw, tbl_basew, tbl_countw}),
        64'({3'b110, 12'd7, 8'h86, 16'h1234, 16'd9}));
    set_def(12'd8, 8'h00, 16'd1, 16'h0);
    tick;
    chk("def_undef", 64'({tbl_we, def_done, def_err}), 64'b001);
    set_def(12'd9, 8'h01, 16'd0, 16'h0);
    tick;
    chk("def_ptr", 64'({tbl_we, def_done, def_err, tbl_lbidw, tbl_typw, tbl_basew, tbl_countw}),
        64'({3'b110, 12'd9, 8'h01, 16'd64, 16'd0}));
    def_valid = 1'b0;
    tick;
    chk("idle_quiet", 64'({tbl_we, def_done, def_err}), 64'd0);

    // Single debug read sets rr to 1
    rd_valid = 2'b10; rd_lbid1 = 12'd7;
    #1 chk("rd1_grant", 64'({rd_ready, tbl_lbid}), 64'({2'b10, 12'd7}));
    tick;
    chk("rd1_rsp", 64'({rsp_valid, rsp_typ, rsp_base, rsp_count}), 64'({2'b10, 8'h86, 16'h1234, 16'd9}));

    // 5: contention alternates 0,1,0,1
    rd_valid = 2'b11; rd_lbid0 = 12'd3; rd_lbid1 = 12'd4;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_grant", 64'(rd_ready), (k % 2 == 1) ? 64'b10 : 64'b01);
      tick;
      if (k % 2 == 1)
        chk("rr_rsp1", 64'({rsp_valid, rsp_typ, rsp_base, rsp_count}), 64'({2'b10, 8'h06, 16'd10, 16'd20}));
      else
        chk("rr_rsp0", 64'({rsp_valid, rsp_typ, rsp_base, rsp_count}), 64'({2'b01, 8'h02, 16'd0, 16'd10}));
    end
    // Redefine lbid3 in the same cycle it is read: read sees the old entry
    set_def(12'd3, 8'h04, 16'd0, 16'h0);
    #1 chk("same_cyc", 64'({def_ready, rd_ready}), 64'b101);
    tick;
    chk("pre_def_rsp", 64'({rsp_valid, rsp_typ, rsp_base, rsp_count}), 64'({2'b01, 8'h02, 16'd0, 16'd10}));
    chk("redef_wr", 64'({tbl_we, def_done, tbl_lbidw, tbl_typw, tbl_basew, tbl_countw}),
        64'({2'b11, 12'd3, 8'h04, 16'd64, 16'd0}));
    def_valid = 1'b0;
    #1 chk("we_inhibit", 64'(rd_ready), 64'd0);
    tick;
    chk("rsp_hold", 64'({rsp_valid, rsp_typ, rsp_base, rsp_count}), 64'({2'b00, 8'h02, 16'd0, 16'd10}));
    #1 chk("rr_after_we", 64'(rd_ready), 64'b10);
    tick;
    chk("rsp_lbid4", 64'({rsp_valid, rsp_typ}), 64'({2'b10, 8'h06}));
    #1 chk("rr_back0", 64'(rd_ready), 64'b01);
    tick;
    chk("post_def_rsp", 64'({rsp_valid, rsp_typ, rsp_base, rsp_count}), 64'({2'b01, 8'h04, 16'd64, 16'd0}));

    // 6: soft clear during reads; define in the same cycle is refused
    clr_req = 1'b1;
    set_def(12'd11, 8'h01, 16'd1, 16'h0);
    #1 chk("clr_block", 64'({def_ready, rd_ready, busy}), 64'd0);
    tick;
    chk("clr_enter", 64'({busy, tbl_we, def_done, def_err, rsp_valid, rsp_typ}), 64'({6'b100000, 8'h04}));
    clr_req = 1'b0; def_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1 chk("clr2_nogrant", 64'({rd_ready, busy}), 64'b001);
      tick;
      chk("clr2_wr", 64'({tbl_we, tbl_lbidw, tbl_typw}), 64'({1'b1, 12'(i), 8'h00}));
    end
    chk("clr2_end", 64'(busy), 64'd0);
    #1 chk("clr2_inh", 64'(rd_ready), 64'd0);
    tick;
    #1 chk("clr2_grant1", 64'(rd_ready), 64'b10);
    tick;
    chk("clr2_rsp1", 64'({rsp_valid, rsp_typ, rsp_base, rsp_count}), 64'({2'b10, 40'h0}));
    tick;
    chk("clr2_rsp0", 64'({rsp_valid, rsp_typ, rsp_base, rsp_count}), 64'({2'b01, 40'h0}));
    rd_valid = 2'b00;
    set_def(12'd6, 8'h05, 16'd5, 16'h0);
    tick;
    chk("clr2_def", 64'({tbl_we, def_done, tbl_lbidw, tbl_typw, tbl_basew, tbl_countw}),
        64'({2'b11, 12'd6, 8'h05, 16'd0, 16'd5}));
    def_valid = 1'b0;

    // Asynchronous reset mid-operation
    rst_n = 1'b0;
    #1 chk("async_rst", 64'({busy, tbl_we, def_done, def_ready}), 64'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
